// File: rtl/assembler_pkg.sv
// Shared ASCII constants, scanner state encoding and character-class helpers.
package assembler_pkg;

  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] TAB   = 8'h09;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] COMMA = 8'h2C;
  localparam logic [7:0] TICK  = 8'h27;
  localparam logic [7:0] NUL   = 8'h00;

  localparam int unsigned MAX_REG = 31;

  typedef enum logic [2:0] {
    StIdle,
    StSkip,
    StReg,
    StImm,
    StDone,
    StErr
  } scan_state_t;

  function automatic logic is_blank(input logic [7:0] c);
    return (c == SPACE) || (c == TAB);
  endfunction

  function automatic logic is_dec(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic logic is_hex(input logic [7:0] c);
    return is_dec(c) || ((c >= 8'h61) && (c <= 8'h66)) || ((c >= 8'h41) && (c <= 8'h46));
  endfunction

  // Characters that may legally end a register operand.
  function automatic logic is_reg_term(input logic [7:0] c);
    return (c == COMMA) || (c == SPACE) || (c == LF) || (c == NUL);
  endfunction

endpackage

// File: rtl/operand_scanner_char_fetch.sv
// Line-buffer reader: address counter plus a valid/address pipe that tags
// BRAM data returning READ_LATENCY cycles after each issued address.
module operand_scanner_char_fetch #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  load_in,
  input  logic [ADDR_WIDTH-1:0] load_addr_in,
  input  logic                  advance_in,
  input  logic                  flush_in,
  output logic [ADDR_WIDTH-1:0] rd_addr_out,
  input  logic [7:0]            rd_data_in,
  output logic [7:0]            char_out,
  output logic [ADDR_WIDTH-1:0] char_addr_out,
  output logic                  char_valid_out
);

  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [READ_LATENCY-1:0] valid_q;
  logic [ADDR_WIDTH-1:0]   addr_pipe_q [READ_LATENCY];

  // Address counter and read-tag pipeline; flush drops every in-flight read.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      addr_q  <= '0;
      valid_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) addr_pipe_q[i] <= '0;
    end else begin
      if (load_in) begin
        addr_q <= load_addr_in;
      end else if (advance_in) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
      end
      valid_q[0]     <= advance_in && !flush_in;
      addr_pipe_q[0] <= addr_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
        valid_q[i]     <= valid_q[i-1] && !flush_in;
        addr_pipe_q[i] <= addr_pipe_q[i-1];
      end
    end
  end

  assign rd_addr_out    = addr_q;
  assign char_out       = rd_data_in;
  assign char_addr_out  = addr_pipe_q[READ_LATENCY-1];
  assign char_valid_out = valid_q[READ_LATENCY-1];

endmodule

// File: rtl/operand_scanner.sv
// Operand scanner: skips blanks, parses "xN" registers locally and streams hex
// immediates into the immediate interpreter, then reports value and next address.
module operand_scanner
  import assembler_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 12,
  parameter int unsigned READ_LATENCY  = 2,
  parameter int unsigned MAX_SKIP      = 8,
  parameter int unsigned MAX_IMM_CHARS = 10
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic [ADDR_WIDTH-1:0] start_addr_in,
  output logic [ADDR_WIDTH-1:0] rd_addr_out,
  input  logic [7:0]            rd_data_in,
  output logic                  imm_trigger_out,
  output logic [7:0]            imm_ascii_out,
  input  logic                  imm_done_in,
  input  logic                  imm_error_in,
  input  logic [31:0]           imm_value_in,
  output logic                  busy_out,
  output logic                  operand_valid_out,
  output logic                  operand_is_reg_out,
  output logic [31:0]           operand_value_out,
  output logic [ADDR_WIDTH-1:0] next_addr_out,
  output logic                  error_out
);

  localparam int unsigned SkipW = $clog2(MAX_SKIP + 1);
  localparam int unsigned ImmW  = $clog2(MAX_IMM_CHARS + 1);

  scan_state_t           state_q, state_d;
  logic [SkipW-1:0]      skip_cnt_q, skip_cnt_d;
  logic [ImmW-1:0]       imm_cnt_q, imm_cnt_d;
  logic [6:0]            val_q, val_d;
  logic [1:0]            digits_q, digits_d;
  logic                  tick_seen_q, tick_seen_d;
  logic [ADDR_WIDTH-1:0] imm_next_q, imm_next_d;
  logic                  is_reg_q, is_reg_d;
  logic [31:0]           value_q, value_d;
  logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;

  logic                  load, advance, flush;
  logic [7:0]            ch;
  logic [ADDR_WIDTH-1:0] ch_addr;
  logic                  ch_valid;

  operand_scanner_char_fetch #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_char_fetch (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .load_in       (load),
    .load_addr_in  (start_addr_in),
    .advance_in    (advance),
    .flush_in      (flush),
    .rd_addr_out   (rd_addr_out),
    .rd_data_in    (rd_data_in),
    .char_out      (ch),
    .char_addr_out (ch_addr),
    .char_valid_out(ch_valid)
  );

  // State and per-scan registers; result fields hold until the next completed scan.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q     <= StIdle;
      skip_cnt_q  <= '0;
      imm_cnt_q   <= '0;
      val_q       <= '0;
      digits_q    <= '0;
      tick_seen_q <= 1'b0;
      imm_next_q  <= '0;
      is_reg_q    <= 1'b0;
      value_q     <= '0;
      next_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      skip_cnt_q  <= skip_cnt_d;
      imm_cnt_q   <= imm_cnt_d;
      val_q       <= val_d;
      digits_q    <= digits_d;
      tick_seen_q <= tick_seen_d;
      imm_next_q  <= imm_next_d;
      is_reg_q    <= is_reg_d;
      value_q     <= value_d;
      next_addr_q <= next_addr_d;
    end
  end

  // Next-state logic, character classification and interpreter feed.
  always_comb begin
    state_d         = state_q;
    skip_cnt_d      = skip_cnt_q;
    imm_cnt_d       = imm_cnt_q;
    val_d           = val_q;
    digits_d        = digits_q;
    tick_seen_d     = tick_seen_q;
    imm_next_d      = imm_next_q;
    is_reg_d        = is_reg_q;
    value_d         = value_q;
    next_addr_d     = next_addr_q;
    load            = 1'b0;
    imm_trigger_out = 1'b0;
    imm_ascii_out   = NUL;
    advance         = (state_q == StSkip) || (state_q == StReg) || (state_q == StImm);

    unique case (state_q)
      StIdle: begin
        if (start_in) begin
          load        = 1'b1;
          state_d     = StSkip;
          skip_cnt_d  = '0;
          imm_cnt_d   = '0;
          val_d       = '0;
          digits_d    = '0;
          tick_seen_d = 1'b0;
          imm_next_d  = '0;
        end
      end
      StSkip: begin
        if (ch_valid) begin
          if (is_blank(ch)) begin
            if (skip_cnt_q == SkipW'(MAX_SKIP)) state_d = StErr;
            else skip_cnt_d = skip_cnt_q + 1'b1;
          end else if ((ch == 8'h78) || (ch == 8'h58)) begin
            state_d = StReg;
          end else if (is_hex(ch)) begin
            imm_trigger_out = 1'b1;
            imm_ascii_out   = ch;
            state_d         = StImm;
          end else begin
            state_d = StErr;
          end
        end
      end
      StReg: begin
        if (ch_valid) begin
          if (is_dec(ch)) begin
            if (digits_q == 2'd2) begin
              state_d = StErr;
            end else begin
              // Low nibble of an ASCII decimal digit is its value.
              val_d    = val_q * 7'd10 + 7'(ch[3:0]);
              digits_d = digits_q + 2'd1;
            end
          end else if (is_reg_term(ch) && (digits_q != 2'd0) && (32'(val_q) <= MAX_REG)) begin
            state_d     = StDone;
            is_reg_d    = 1'b1;
            value_d     = 32'(val_q);
            next_addr_d = ch_addr;
          end else begin
            state_d = StErr;
          end
        end
      end
      StImm: begin
        // Forward up to and including the closing tick, then go quiet.
        if (ch_valid && !tick_seen_q) begin
          imm_ascii_out = ch;
          if (ch == TICK) begin
            tick_seen_d = 1'b1;
            imm_next_d  = ch_addr + ADDR_WIDTH'(1);
          end
        end
        if (imm_error_in) begin
          state_d = StErr;
        end else if (imm_done_in) begin
          state_d     = StDone;
          is_reg_d    = 1'b0;
          value_d     = imm_value_in;
          next_addr_d = imm_next_d;
        end else if (ch_valid) begin
          if (imm_cnt_q == ImmW'(MAX_IMM_CHARS)) state_d = StErr;
          else imm_cnt_d = imm_cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    flush = (state_d == StDone) || (state_d == StErr);
  end

  assign busy_out           = (state_q != StIdle);
  assign operand_valid_out  = (state_q == StDone);
  assign error_out          = (state_q == StErr);
  assign operand_is_reg_out = is_reg_q;
  assign operand_value_out  = value_q;
  assign next_addr_out      = next_addr_q;

endmodule

// File: tb/tb_operand_scanner.sv
// Bench for operand_scanner: BRAM model, hex interpreter stand-in, directed
// scenarios and randomized operands checked against a string-level model.
module tb_operand_scanner;

  localparam int unsigned AW = 12;
  localparam int unsigned RL = 2;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          start_in = 1'b0;
  logic [AW-1:0] start_addr_in = '0;
  logic [AW-1:0] rd_addr_out;
  logic [7:0]    rd_data_in;
  logic          imm_trigger_out;
  logic [7:0]    imm_ascii_out;
  logic          imm_done_in = 1'b0;
  logic          imm_error_in = 1'b0;
  logic [31:0]   imm_value_in = '0;
  logic          busy_out, operand_valid_out, operand_is_reg_out, error_out;
  logic [31:0]   operand_value_out;
  logic [AW-1:0] next_addr_out;

  int total = 0;
  int bad = 0;

  always #5 clk_in = ~clk_in;

  operand_scanner #(
    .ADDR_WIDTH   (AW),
    .READ_LATENCY (RL),
    .MAX_SKIP     (8),
    .MAX_IMM_CHARS(10)
  ) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .start_in          (start_in),
    .start_addr_in     (start_addr_in),
    .rd_addr_out       (rd_addr_out),
    .rd_data_in        (rd_data_in),
    .imm_trigger_out   (imm_trigger_out),
    .imm_ascii_out     (imm_ascii_out),
    .imm_done_in       (imm_done_in),
    .imm_error_in      (imm_error_in),
    .imm_value_in      (imm_value_in),
    .busy_out          (busy_out),
    .operand_valid_out (operand_valid_out),
    .operand_is_reg_out(operand_is_reg_out),
    .operand_value_out (operand_value_out),
    .next_addr_out     (next_addr_out),
    .error_out         (error_out)
  );

  // Line buffer with RL-cycle registered read.
  logic [7:0] mem [4096];
  logic [7:0] d_pipe [RL];
  always @(posedge clk_in) begin
    d_pipe[0] <= mem[rd_addr_out];
    for (int i = 1; i < RL; i++) d_pipe[i] <= d_pipe[i-1];
  end
  assign rd_data_in = d_pipe[RL-1];

  function automatic int hexval(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
    return -1;
  endfunction

  // Immediate interpreter stand-in: accumulates hex, done one cycle after the tick.
  logic        stub_active = 1'b0;
  logic [31:0] stub_acc = '0;
  always @(posedge clk_in) begin
    imm_done_in  <= 1'b0;
    imm_error_in <= 1'b0;
    if (!rst_in) begin
      stub_active  <= 1'b0;
      stub_acc     <= '0;
      imm_value_in <= '0;
    end else if (imm_trigger_out) begin
      stub_active <= 1'b1;
      stub_acc    <= 32'(hexval(imm_ascii_out));
    end else if (stub_active && imm_ascii_out != 8'h00) begin
      if (imm_ascii_out == 8'h27) begin
        imm_done_in  <= 1'b1;
        imm_value_in <= stub_acc;
        stub_active  <= 1'b0;
      end else if (hexval(imm_ascii_out) >= 0) begin
        stub_acc <= (stub_acc << 4) | 32'(hexval(imm_ascii_out));
      end else begin
        imm_error_in <= 1'b1;
        stub_active  <= 1'b0;
      end
    end
  end

  task automatic load_str(input logic [AW-1:0] a, input string s);
    for (int i = 0; i < 40; i++) mem[AW'(int'(a) + i)] = 8'h00;
    for (int i = 0; i < s.len(); i++) mem[AW'(int'(a) + i)] = s[i];
  endtask

  // Expected outcome of a scan starting at a, straight from the operand grammar.
  task automatic model(input logic [AW-1:0] a, output bit e, output bit r,
                       output logic [31:0] v, output logic [AW-1:0] nx, output bit t);
    logic [AW-1:0] p;
    logic [7:0]    c;
    int            blanks, digits;
    bit            fin;
    p = a; e = 0; r = 0; v = '0; nx = '0; t = 0; blanks = 0;
    while (mem[p] == 8'h20 || mem[p] == 8'h09) begin
      blanks++;
      p++;
    end
    if (blanks > 8) begin
      e = 1;
      return;
    end
    c = mem[p];
    if (c == 8'h78 || c == 8'h58) begin
      r = 1; p++; digits = 0;
      while (mem[p] >= 8'h30 && mem[p] <= 8'h39) begin
        digits++;
        v = v * 10 + 32'(mem[p] - 8'h30);
        p++;
      end
      c = mem[p];
      if (digits < 1 || digits > 2 || v > 31) e = 1;
      else if (c == 8'h2C || c == 8'h20 || c == 8'h0A || c == 8'h00) nx = p;
      else e = 1;
    end else if (hexval(c) >= 0) begin
      t = 1; v = 32'(hexval(c)); p++; fin = 0;
      for (int j = 1; !fin; j++) begin
        c = mem[p];
        if (j > 10) begin
          e = 1; fin = 1;
        end else if (c == 8'h27) begin
          nx = p + AW'(1); fin = 1;
        end else if (hexval(c) < 0) begin
          e = 1; fin = 1;
        end else begin
          v = (v << 4) | 32'(hexval(c));
          p++;
        end
      end
    end else begin
      e = 1;
    end
  endtask

  // Pulse start, then watch for the result pulse with a bounded cycle budget.
  task automatic run_scan(input logic [AW-1:0] a, output bit got_v, output bit got_e,
                          output int cyc, output int ntrig, output int nasc, output bit r_reg,
                          output logic [31:0] r_val, output logic [AW-1:0] r_next);
    got_v = 0; got_e = 0; cyc = -1; ntrig = 0; nasc = 0; r_reg = 0; r_val = '0; r_next = '0;
    @(negedge clk_in);
    start_in = 1'b1;
    start_addr_in = a;
    @(negedge clk_in);
    start_in = 1'b0;
    for (int n = 0; n <= 60; n++) begin
      if (n > 0) @(negedge clk_in);
      if (imm_trigger_out) ntrig++;
      if (imm_ascii_out != 8'h00) nasc++;
      if (operand_valid_out) begin
        got_v = 1; cyc = n;
        r_reg = operand_is_reg_out; r_val = operand_value_out; r_next = next_addr_out;
      end
      if (error_out) begin
        got_e = 1; cyc = n;
      end
      if (got_v || got_e) break;
    end
    @(negedge clk_in);
  endtask

  bit            gv, ge, rr;
  int            cy, nt, na;
  logic [31:0]   rv;
  logic [AW-1:0] rn;

  task automatic test_reset();
    repeat (3) @(negedge clk_in);
    total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_out); end
    total++; if (operand_valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", operand_valid_out); end
    total++; if (error_out !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", error_out); end
    total++; if (rd_addr_out !== '0) begin bad++; $display("FAIL reset_rd_addr: got %0d want 0", rd_addr_out); end
    total++; if (imm_trigger_out !== 1'b0 || imm_ascii_out !== 8'h00) begin
      bad++; $display("FAIL reset_imm: got trig=%b ascii=%h want 0/00", imm_trigger_out, imm_ascii_out);
    end
    total++; if (operand_value_out !== '0 || next_addr_out !== '0 || operand_is_reg_out !== 1'b0) begin
      bad++; $display("FAIL reset_result: got val=%h next=%0d reg=%b want 0", operand_value_out,
                      next_addr_out, operand_is_reg_out);
    end
    rst_in = 1'b1;
    @(negedge clk_in);
  endtask

  task automatic test_reg_basic();
    load_str(12'd0, "  x17,");
    run_scan(12'd0, gv, ge, cy, nt, na, rr, rv, rn);
    total++; if (gv !== 1'b1 || ge !== 1'b0) begin bad++; $display("FAIL reg_basic_flags: got v=%b e=%b want 1/0", gv, ge); end
    total++; if (rr !== 1'b1 || rv !== 32'd17) begin bad++; $display("FAIL reg_basic_value: got reg=%b val=%0d want 1/17", rr, rv); end
    total++; if (rn !== 12'd5) begin bad++; $display("FAIL reg_basic_next: got %0d want 5", rn); end
    total++; if (nt !== 0 || na !== 0) begin bad++; $display("FAIL reg_basic_quiet: got trig=%0d ascii=%0d want 0/0", nt, na); end
  endtask

  task automatic test_latency();
    load_str(12'd300, "x5,");
    run_scan(12'd300, gv, ge, cy, nt, na, rr, rv, rn);
    total++; if (gv !== 1'b1 || cy !== 5) begin bad++; $display("FAIL latency_x5: got v=%b cycle=%0d want 1/5", gv, cy); end
    total++; if (rv !== 32'd5 || rn !== 12'd302) begin bad++; $display("FAIL latency_value: got val=%0d next=%0d want 5/302", rv, rn); end
    total++; if (operand_valid_out !== 1'b0 || busy_out !== 1'b0) begin
      bad++; $display("FAIL valid_one_cycle: got valid=%b busy=%b want 0/0", operand_valid_out, busy_out);
    end
  endtask

  task automatic test_imm_basic();
    load_str(12'd0, "1F'");
    run_scan(12'd0, gv, ge, cy, nt, na, rr, rv, rn);
    total++; if (gv !== 1'b1 || ge !== 1'b0) begin bad++; $display("FAIL imm_basic_flags: got v=%b e=%b want 1/0", gv, ge); end
    total++; if (rr !== 1'b0 || rv !== 32'h1F) begin bad++; $display("FAIL imm_basic_value: got reg=%b val=%h want 0/1f", rr, rv); end
    total++; if (rn !== 12'd3) begin bad++; $display("FAIL imm_basic_next: got %0d want 3", rn); end
    total++; if (nt !== 1) begin bad++; $display("FAIL imm_basic_trigger: got %0d want 1", nt); end
  endtask

  task automatic test_reg_errors();
    load_str(12'd600, "x32,");
    run_scan(12'd600, gv, ge, cy, nt, na, rr, rv, rn);
    total++; if (ge !== 1'b1 || gv !== 1'b0) begin bad++; $display("FAIL reg_x32: got e=%b v=%b want 1/0", ge, gv); end
    load_str(12'd650, "x,");
    run_scan(12'd650, gv, ge, cy, nt, na, rr, rv, rn);
    total++; if (ge !== 1'b1 || gv !== 1'b0) begin bad++; $display("FAIL reg_nodigit: got e=%b v=%b want 1/0", ge, gv); end
    load_str(12'd700, "x123,");
    run_scan(12'd700, gv, ge, cy, nt, na, rr, rv, rn);
    total++; if (ge !== 1'b1) begin bad++; $display("FAIL reg_3digit: got e=%b want 1", ge); end
  endtask

  task automatic test_bad_first();
    load_str(12'd800, "G5");
    run_scan(12'd800, gv, ge, cy, nt, na, rr, rv, rn);
    total++; if (ge !== 1'b1 || cy > int'(RL) + 1) begin bad++; $display("FAIL bad_first: got e=%b cycle=%0d want 1/<=3", ge, cy); end
    total++; if (nt !== 0) begin bad++; $display("FAIL bad_first_trigger: got %0d want 0", nt); end
  endtask

  task automatic test_limits();
    string s;
    load_str(12'd900, "123456789ABC'");
    run_scan(12'd900, gv, ge, cy, nt, na, rr, rv, rn);
    total++; if (ge !== 1'b1 || gv !== 1'b0) begin bad++; $display("FAIL imm_too_long: got e=%b v=%b want 1/0", ge, gv); end
    load_str(12'd950, "123456789A'");
    run_scan(12'd950, gv, ge, cy, nt, na, rr, rv, rn);
    total++; if (gv !== 1'b1 || rv !== 32'h3456789A || rn !== 12'd961) begin
      bad++; $display("FAIL imm_at_limit: got v=%b val=%h next=%0d want 1/3456789a/961", gv, rv, rn);
    end
    s = "";
    for (int i = 0; i < 9; i++) s = {s, " "};
    load_str(12'd1000, {s, "x1"});
    run_scan(12'd1000, gv, ge, cy, nt, na, rr, rv, rn);
    total++; if (ge !== 1'b1) begin bad++; $display("FAIL skip_9: got e=%b want 1", ge); end
    s = "";
    for (int i = 0; i < 8; i++) s = {s, " "};
    load_str(12'd1050, {s, "x1,"});
    run_scan(12'd1050, gv, ge, cy, nt, na, rr, rv, rn);
    total++; if (gv !== 1'b1 || rv !== 32'd1 || rn !== 12'd1060) begin
      bad++; $display("FAIL skip_8: got v=%b val=%0d next=%0d want 1/1/1060", gv, rv, rn);
    end
  endtask

  task automatic test_wrap();
    load_str(12'd4094, "x12,");
    run_scan(12'd4094, gv, ge, cy, nt, na, rr, rv, rn);
    total++; if (gv !== 1'b1 || rv !== 32'd12 || rn !== 12'd1) begin
      bad++; $display("FAIL addr_wrap: got v=%b val=%0d next=%0d want 1/12/1", gv, rv, rn);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    load_str(12'd100, "1234567'");
    @(negedge clk_in);
    start_in = 1'b1; start_addr_in = 12'd100;
    @(negedge clk_in);
    start_in = 1'b0;
    repeat (4) @(negedge clk_in);
    rst_in = 1'b0;
    repeat (2) begin
      @(negedge clk_in);
      if (operand_valid_out || error_out) pulses++;
    end
    rst_in = 1'b1;
    repeat (3) begin
      @(negedge clk_in);
      if (operand_valid_out || error_out) pulses++;
    end
    total++; if (pulses !== 0 || busy_out !== 1'b0) begin
      bad++; $display("FAIL reset_mid_abort: got pulses=%0d busy=%b want 0/0", pulses, busy_out);
    end
    load_str(12'd200, "x3 ");
    run_scan(12'd200, gv, ge, cy, nt, na, rr, rv, rn);
    total++; if (gv !== 1'b1 || rv !== 32'd3 || rn !== 12'd202) begin
      bad++; $display("FAIL reset_mid_rescan: got v=%b val=%0d next=%0d want 1/3/202", gv, rv, rn);
    end
    total++; if (nt !== 0 || na !== 0) begin bad++; $display("FAIL reset_mid_stale: got trig=%0d ascii=%0d want 0/0", nt, na); end
  endtask

  task automatic test_busy_start();
    bit seen;
    seen = 0;
    load_str(12'd400, "x5,");
    load_str(12'd500, "x9,");
    @(negedge clk_in);
    start_in = 1'b1; start_addr_in = 12'd400;
    @(negedge clk_in);
    start_in = 1'b0;
    @(negedge clk_in);
    start_in = 1'b1; start_addr_in = 12'd500;
    @(negedge clk_in);
    start_in = 1'b0;
    for (int n = 0; n < 30 && !seen; n++) begin
      @(negedge clk_in);
      if (operand_valid_out) begin
        seen = 1; rv = operand_value_out; rn = next_addr_out;
      end
    end
    total++; if (seen !== 1'b1 || rv !== 32'd5 || rn !== 12'd402) begin
      bad++; $display("FAIL start_while_busy: got seen=%b val=%0d next=%0d want 1/5/402", seen, rv, rn);
    end
    repeat (2) @(negedge clk_in);
  endtask

  task automatic gen_random(input logic [AW-1:0] a);
    logic [AW-1:0] p;
    logic [7:0]    terms [6];
    logic [7:0]    junk [6];
    int            kind, nd, zpos, hv;
    terms = '{8'h2C, 8'h20, 8'h0A, 8'h00, 8'h71, 8'h2E};
    junk  = '{8'h47, 8'h23, 8'h2C, 8'h0A, 8'h00, 8'h5F};
    for (int i = 0; i < 40; i++) mem[AW'(int'(a) + i)] = 8'h00;
    p = a;
    repeat ($urandom_range(0, 9)) begin
      mem[p] = ($urandom_range(0, 3) == 0) ? 8'h09 : 8'h20;
      p++;
    end
    kind = $urandom_range(0, 3);
    if (kind == 0) begin
      mem[p] = ($urandom_range(0, 1) != 0) ? 8'h78 : 8'h58; p++;
      nd = $urandom_range(0, 3);
      for (int i = 0; i < nd; i++) begin
        mem[p] = 8'h30 + 8'((i == 0) ? $urandom_range(0, 4) : $urandom_range(0, 9)); p++;
      end
      mem[p] = terms[$urandom_range(0, 5)];
    end else if (kind <= 2) begin
      nd = $urandom_range(1, 12);
      zpos = (nd > 1 && $urandom_range(0, 5) == 0) ? int'($urandom_range(1, nd - 1)) : -1;
      for (int i = 0; i < nd; i++) begin
        hv = $urandom_range(0, 15);
        if (i == zpos) mem[p] = 8'h7A;
        else if (hv < 10) mem[p] = 8'h30 + 8'(hv);
        else mem[p] = (($urandom_range(0, 1) != 0) ? 8'h61 : 8'h41) + 8'(hv - 10);
        p++;
      end
      mem[p] = 8'h27;
    end else begin
      mem[p] = junk[$urandom_range(0, 5)];
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a, enx;
    logic [31:0]   ev;
    bit            ee, er, et;
    for (int it = 0; it < 60; it++) begin
      a = AW'($urandom_range(0, 4095));
      gen_random(a);
      model(a, ee, er, ev, enx, et);
      run_scan(a, gv, ge, cy, nt, na, rr, rv, rn);
      total++; if (ge !== ee || gv !== !ee) begin
        bad++; $display("FAIL rand_outcome[%0d]: got v=%b e=%b want e=%b (addr %0d)", it, gv, ge, ee, a);
      end
      total++; if (nt !== int'(et)) begin bad++; $display("FAIL rand_trigger[%0d]: got %0d want %0d", it, nt, et); end
      if (!ee && gv) begin
        total++; if (rr !== er || rv !== ev || rn !== enx) begin
          bad++; $display("FAIL rand_result[%0d]: got reg=%b val=%h next=%0d want %b/%h/%0d",
                          it, rr, rv, rn, er, ev, enx);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    test_reset();
    test_reg_basic();
    test_latency();
    test_imm_basic();
    test_reg_errors();
    test_bad_first();
    test_limits();
    test_wrap();
    test_reset_mid();
    test_busy_start();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
